// File: rtl/int_arbiter_if.sv
// Bus bundle between the interrupt arbiter and the CPU-side logic.
// The slave modport is the arbiter's view; master is the CPU/bench view.
interface int_arbiter_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] SRC_REQ;
    logic [7:0]       PORT_ID;
    logic [7:0]       OUT_PORT;
    logic             IO_STRB;
    logic             INTERRUPT;
    logic [7:0]       SRC_ID;
    logic [N_SRC-1:0] PENDING;
    logic             BUSY;

    modport slave (
        input  SRC_REQ, PORT_ID, OUT_PORT, IO_STRB,
        output INTERRUPT, SRC_ID, PENDING, BUSY
    );

    modport master (
        output SRC_REQ, PORT_ID, OUT_PORT, IO_STRB,
        input  INTERRUPT, SRC_ID, PENDING, BUSY
    );
endinterface

// File: rtl/int_arbiter.sv
// Fixed-priority interrupt arbiter: edge-detects N_SRC request lines, keeps
// masked pending flags, pulses INTERRUPT to the CPU and waits for a port-write
// acknowledge, re-pulsing the same source if the acknowledge never comes.
module int_arbiter #(
    parameter int         N_SRC     = 4,
    parameter int         PULSE_LEN = 2,
    parameter int         TIMEOUT   = 1023,
    parameter logic [7:0] ACK_ID    = 8'h46,
    parameter logic [7:0] MASK_ID   = 8'h47
) (
    input  logic         CLK,
    input  logic         RESET,
    int_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ASSERT = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]       state;
    logic [N_SRC-1:0] prev_req;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pending;
    logic [7:0]       src_id;
    logic [PW-1:0]    pulse_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             irq;

    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] clr_vec;
    logic [N_SRC-1:0] ready;
    logic [7:0]       pick_idx;
    logic             mask_wr;
    logic             ack;

    // Only the low N_SRC bits of the data bus carry mask bits.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.OUT_PORT};

    assign set_vec = bus.SRC_REQ & ~prev_req & mask;
    assign mask_wr = bus.IO_STRB && (bus.PORT_ID == MASK_ID);
    assign ack     = bus.IO_STRB && (bus.PORT_ID == ACK_ID) && (state == S_WAIT);
    assign ready   = pending & mask;

    // Acknowledge clears only the bit of the source currently in service.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (ack && (src_id == 8'(i))) clr_vec[i] = 1'b1;
        end
    end

    // Lowest ready index wins; scanning downward lets index 0 override.
    always_comb begin
        pick_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (ready[i]) pick_idx = 8'(i);
        end
    end

    // Edge detect, mask register and pending flags (a new set beats a clear).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_req <= '1;
            mask     <= '1;
            pending  <= '0;
        end else begin
            prev_req <= bus.SRC_REQ;
            pending  <= (pending & ~clr_vec) | set_vec;
            if (mask_wr) mask <= bus.OUT_PORT[N_SRC-1:0];
        end
    end

    // Service FSM: pick a source, pulse INTERRUPT, wait for ack or timeout.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            irq       <= 1'b0;
            src_id    <= 8'hFF;
            pulse_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|ready) begin
                        src_id    <= pick_idx;
                        pulse_cnt <= PW'(PULSE_LEN);
                        irq       <= 1'b1;
                        state     <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (pulse_cnt == PW'(1)) begin
                        irq     <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_WAIT;
                    end else begin
                        pulse_cnt <= pulse_cnt - PW'(1);
                    end
                end
                S_WAIT: begin
                    if (ack) begin
                        src_id <= 8'hFF;
                        state  <= S_IDLE;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        pulse_cnt <= PW'(PULSE_LEN);
                        irq       <= 1'b1;
                        state     <= S_ASSERT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    irq    <= 1'b0;
                    src_id <= 8'hFF;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.INTERRUPT = irq;
    assign bus.SRC_ID    = src_id;
    assign bus.PENDING   = pending;
    assign bus.BUSY      = (state != S_IDLE);

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed scenarios followed by randomized traffic.
// Expected service order is pushed into a queue by a pending-set model and
// popped by an independent monitor on every INTERRUPT rising edge.
module tb_int_arbiter;
    localparam int         N   = 4;
    localparam int         PL  = 2;
    localparam int         TO  = 8;
    localparam logic [7:0] ACK = 8'h46;
    localparam logic [7:0] MSK = 8'h47;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int_arbiter_if #(.N_SRC(N)) ifc();

    int_arbiter #(
        .N_SRC(N), .PULSE_LEN(PL), .TIMEOUT(TO), .ACK_ID(ACK), .MASK_ID(MSK)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .bus(ifc)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int exp_q[$];

    // reference model state
    logic [N-1:0] m_prev, m_mask, m_pend;
    bit           m_busy;
    int           m_cur;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int lowest(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_pick();
        int p;
        if (!m_busy) begin
            p = lowest(m_pend & m_mask);
            if (p >= 0) begin
                exp_q.push_back(p);
                m_cur  = p;
                m_busy = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs and advance the model by the same edge.
    task automatic cyc(logic [N-1:0] req, bit strb, logic [7:0] pid, logic [7:0] dat, bit do_ack);
        logic [N-1:0] set_v;
        ifc.SRC_REQ  = req;
        ifc.IO_STRB  = strb;
        ifc.PORT_ID  = pid;
        ifc.OUT_PORT = dat;
        set_v = req & ~m_prev & m_mask;
        if (do_ack) begin
            m_pend[m_cur] = 1'b0;
            m_busy = 1'b0;
        end
        m_pend = m_pend | set_v;
        m_prev = req;
        if (strb && pid == MSK) m_mask = dat[N-1:0];
        model_pick();
        @(negedge clk);
        ifc.IO_STRB = 1'b0;
    endtask

    task automatic idle_n(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_irq(bit lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.INTERRUPT === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL irq_wait: INTERRUPT=%0b after 40 cycles, wanted %0b", ifc.INTERRUPT, lvl);
        end
    endtask

    task automatic do_reset(logic [N-1:0] req, int n);
        rst         = 1'b1;
        ifc.SRC_REQ = req;
        ifc.IO_STRB = 1'b0;
        repeat (n) @(negedge clk);
        rst    = 1'b0;
        m_pend = '0;
        m_mask = '1;
        m_prev = '1;
        m_busy = 1'b0;
        exp_q.delete();
    endtask

    // Wait for a pulse, optionally poke at the DUT during WAIT_ACK, then ack.
    task automatic serve(bit rnd);
        bit ok;
        int k;
        logic [N-1:0] r;
        wait_irq(1'b1, ok);
        wait_irq(1'b0, ok);
        r = ifc.SRC_REQ;
        if (rnd) begin
            k = $urandom_range(0, 3);
            repeat (k) begin
                if ($urandom_range(0, 3) == 0)
                    cyc(r, 1'b1, MSK, 8'($urandom_range(1, 15)), 1'b0);
                else begin
                    r = N'($urandom);
                    cyc(r, 1'b0, 8'h00, 8'h00, 1'b0);
                end
            end
            if ($urandom_range(0, 1) == 1) r = N'($urandom);
        end
        cyc(r, 1'b1, ACK, 8'($urandom), 1'b1);
        chk("pending_after_ack", 32'(ifc.PENDING), 32'(m_pend));
        chk("srcid_after_ack", 32'(ifc.SRC_ID), 32'hFF);
    endtask

    // cycle counter for interval measurements
    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // monitor: each INTERRUPT rise must match the next expected service
    initial begin
        bit irq_q;
        int hi_len;
        int e;
        irq_q  = 1'b0;
        hi_len = 0;
        forever begin
            @(negedge clk);
            if (ifc.INTERRUPT === 1'b1 && !irq_q) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_irq: SRC_ID=%0h with no service expected", ifc.SRC_ID);
                end else begin
                    e = exp_q.pop_front();
                    if (ifc.SRC_ID !== 8'(e)) begin
                        failures++;
                        $display("FAIL service_src: got SRC_ID=%0h expected %0h", ifc.SRC_ID, e);
                    end
                end
            end
            if (ifc.INTERRUPT === 1'b1) hi_len++;
            else begin
                if (irq_q) begin
                    checks++;
                    if (hi_len != PL) begin
                        failures++;
                        $display("FAIL pulse_len: got %0d cycles expected %0d", hi_len, PL);
                    end
                end
                hi_len = 0;
            end
            irq_q = (ifc.INTERRUPT === 1'b1);
        end
    end

    initial begin
        bit ok;
        int t0, t1;
        logic [N-1:0] r;
        ifc.SRC_REQ  = '0;
        ifc.IO_STRB  = 1'b0;
        ifc.PORT_ID  = 8'h00;
        ifc.OUT_PORT = 8'h00;
        m_cur = 0;

        // reset values
        do_reset('0, 3);
        chk("rst_irq", 32'(ifc.INTERRUPT), 0);
        chk("rst_srcid", 32'(ifc.SRC_ID), 32'hFF);
        chk("rst_pending", 32'(ifc.PENDING), 0);
        chk("rst_busy", 32'(ifc.BUSY), 0);

        // lines held high through reset release must not fire
        do_reset('1, 2);
        idle_n(10);
        chk("holdoff_pending", 32'(ifc.PENDING), 0);
        chk("holdoff_busy", 32'(ifc.BUSY), 0);
        cyc('0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle_n(2);

        // single source with exact timing
        cyc(4'b0010, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("single_pend", 32'(ifc.PENDING), 32'b0010);
        chk("single_irq_t0", 32'(ifc.INTERRUPT), 0);
        @(negedge clk);
        chk("single_irq_t1", 32'(ifc.INTERRUPT), 1);
        chk("single_srcid", 32'(ifc.SRC_ID), 1);
        chk("single_busy", 32'(ifc.BUSY), 1);
        @(negedge clk);
        chk("single_irq_t2", 32'(ifc.INTERRUPT), 1);
        @(negedge clk);
        chk("single_irq_t3", 32'(ifc.INTERRUPT), 0);
        chk("single_busy_wait", 32'(ifc.BUSY), 1);
        idle_n(1);
        cyc(4'b0010, 1'b1, ACK, 8'h00, 1'b1);
        chk("single_pend_ack", 32'(ifc.PENDING), 0);
        chk("single_srcid_ack", 32'(ifc.SRC_ID), 32'hFF);
        chk("single_busy_ack", 32'(ifc.BUSY), 0);
        cyc('0, 1'b0, 8'h00, 8'h00, 1'b0);

        // simultaneous rises: 0 then 3
        cyc(4'b1001, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("prio_pend", 32'(ifc.PENDING), 32'b1001);
        serve(1'b0);
        serve(1'b0);
        cyc('0, 1'b0, 8'h00, 8'h00, 1'b0);

        // masked source dropped, unmasked serviced
        cyc('0, 1'b1, MSK, 8'h0E, 1'b0);
        cyc(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0);
        idle_n(6);
        chk("mask_pend", 32'(ifc.PENDING), 0);
        chk("mask_irq", 32'(ifc.INTERRUPT), 0);
        cyc(4'b0101, 1'b0, 8'h00, 8'h00, 1'b0);
        serve(1'b0);
        cyc('0, 1'b0, 8'h00, 8'h00, 1'b0);
        cyc('0, 1'b1, MSK, 8'h0F, 1'b0);

        // timeout re-pulse every TO+PL cycles
        cyc(4'b0010, 1'b0, 8'h00, 8'h00, 1'b0);
        exp_q.push_back(1);
        exp_q.push_back(1);
        wait_irq(1'b1, ok);
        t0 = cyc_cnt;
        wait_irq(1'b0, ok);
        wait_irq(1'b1, ok);
        t1 = cyc_cnt;
        chk("timeout_period1", 32'(t1 - t0), 32'(TO + PL));
        wait_irq(1'b0, ok);
        wait_irq(1'b1, ok);
        t0 = cyc_cnt;
        chk("timeout_period2", 32'(t0 - t1), 32'(TO + PL));
        chk("timeout_srcid", 32'(ifc.SRC_ID), 1);
        wait_irq(1'b0, ok);
        cyc(4'b0010, 1'b1, ACK, 8'h00, 1'b1);
        chk("timeout_pend_ack", 32'(ifc.PENDING), 0);
        cyc('0, 1'b0, 8'h00, 8'h00, 1'b0);

        // ack coincident with new rise of same source
        cyc(4'b0100, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_irq(1'b1, ok);
        wait_irq(1'b0, ok);
        cyc('0, 1'b0, 8'h00, 8'h00, 1'b0);
        cyc(4'b0100, 1'b1, ACK, 8'h00, 1'b1);
        chk("collide_pend", 32'(ifc.PENDING), 32'b0100);
        chk("collide_srcid", 32'(ifc.SRC_ID), 32'hFF);
        serve(1'b0);
        cyc('0, 1'b0, 8'h00, 8'h00, 1'b0);

        // reset while waiting for ack
        cyc(4'b1000, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_irq(1'b1, ok);
        wait_irq(1'b0, ok);
        chk("rstwait_busy_before", 32'(ifc.BUSY), 1);
        do_reset(4'b1000, 1);
        chk("rstwait_irq", 32'(ifc.INTERRUPT), 0);
        chk("rstwait_srcid", 32'(ifc.SRC_ID), 32'hFF);
        chk("rstwait_pend", 32'(ifc.PENDING), 0);
        chk("rstwait_busy", 32'(ifc.BUSY), 0);
        cyc('0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle_n(3);

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            if (m_busy) serve(1'b1);
            else if ($urandom_range(0, 5) == 0) begin
                r = ifc.SRC_REQ;
                cyc(r, 1'b1, MSK, 8'h0F, 1'b0);
            end else begin
                r = N'($urandom);
                cyc(r, 1'b0, 8'h00, 8'h00, 1'b0);
            end
        end
        for (int k = 0; k < 10; k++) if (m_busy) serve(1'b0);
        idle_n(5);
        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("final_pend", 32'(ifc.PENDING), 32'(m_pend));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter N_SRC, 4: number of interrupt sources, range 2..8.
REQ-002 Parameter PULSE_LEN, 2: number of CLK cycles INTERRUPT is held high; minimum 2, because the CPU runs at CLK/2.
REQ-003 Parameter TIMEOUT, 1023: number of WAIT_ACK cycles before a re-assert.
REQ-004 Parameter ACK_ID, 8'h46: output port ID for the acknowledge write.
REQ-005 Parameter MASK_ID, 8'h47: output port ID for the mask write.
REQ-006 CLK  in  1  single clock; one clock, all logic on rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 SRC_REQ  in  N_SRC  interrupt request lines, one per source, already synchronous to CLK.
REQ-009 PORT_ID  in  8  CPU port ID.
REQ-010 OUT_PORT  in  8  CPU output data.
REQ-011 IO_STRB  in  1  CPU output strobe.
REQ-012 INTERRUPT  out  1  registered interrupt line to the CPU.
REQ-013 SRC_ID  out  8  index of the source being serviced; 8'hFF when idle.
REQ-014 PENDING  out  N_SRC  pending flags.
REQ-015 BUSY  out  1  high whenever state != IDLE.

Function
REQ-016 Edge detect: prev_req SHALL be registered every cycle; a rise is SRC_REQ[i] & ~prev_req[i].
REQ-017 A rise on source i with mask[i]=1 SHALL set pending[i] at that clock edge; a rise with mask[i]=0 SHALL be dropped.
REQ-018 Mask write: IO_STRB=1 and PORT_ID=MASK_ID SHALL load mask <= OUT_PORT[N_SRC-1:0].
- Mask write does not clear existing pending bits.
- Mask write does not abort a source already in service.
REQ-019 FSM states SHALL be IDLE, ASSERT, WAIT_ACK.
REQ-020 IDLE: if (pending & mask) != 0, the FSM SHALL:
- latch SRC_ID = lowest set index (fixed priority, index 0 highest);
- load the pulse counter with PULSE_LEN;
- move to ASSERT.
REQ-021 ASSERT: INTERRUPT SHALL be 1 for exactly PULSE_LEN cycles, then the FSM moves to WAIT_ACK with the timeout counter cleared.
REQ-022 WAIT_ACK: IO_STRB=1 and PORT_ID=ACK_ID SHALL:
- clear pending[SRC_ID];
- set SRC_ID to 8'hFF;
- return to IDLE.
OUT_PORT is ignored for the acknowledge.
REQ-023 WAIT_ACK timeout: if no acknowledge arrives within TIMEOUT cycles, the FSM SHALL re-enter ASSERT for the same SRC_ID and reload the pulse counter.
REQ-024 Acknowledge writes in IDLE or ASSERT SHALL be ignored.
REQ-025 Latency: a rise sampled at edge t sets pending after t; INTERRUPT goes high after edge t+1, provided the FSM is IDLE.
REQ-026 Acknowledge and a new rise of the same source in the same cycle: the set wins, pending stays 1, and the source is serviced again.
REQ-027 Rises on other sources while BUSY SHALL accumulate in PENDING and be serviced in priority order after the acknowledge.
- At least one IDLE cycle with INTERRUPT=0 occurs between services.
REQ-028 Repeated rises of a source that is already pending SHALL be coalesced into one service.
REQ-029 INTERRUPT SHALL be 0 in IDLE and WAIT_ACK.

Reset
REQ-030 RESET=1 at a clock edge SHALL set:
- state = IDLE;
- INTERRUPT = 0;
- SRC_ID = 8'hFF;
- PENDING = 0;
- BUSY = 0;
- mask = all ones;
- counters = 0;
- prev_req = all ones, so lines held high through reset do not fire.
REQ-031 RESET during ASSERT or WAIT_ACK SHALL abort service immediately; the in-flight request is lost.

Verification
REQ-032 Single source:
- Stimulus: SRC_REQ=4'b0010 rise, then acknowledge write after 5 cycles.
- Response: INTERRUPT high 2 cycles starting 2 cycles after the rise; SRC_ID=1; PENDING=0 and SRC_ID=8'hFF after the acknowledge.
REQ-033 Priority:
- Stimulus: SRC_REQ rises 4'b1001 in the same cycle.
- Response: source 0 serviced first; after its acknowledge, SRC_ID=3 and INTERRUPT re-pulses.
REQ-034 Mask:
- Stimulus: mask write 8'h0E, then rise on source 0.
- Response: PENDING stays 0 and INTERRUPT stays 0.
- Stimulus: rise on source 2.
- Response: source 2 is serviced.
REQ-035 Timeout (TIMEOUT=8):
- Stimulus: no acknowledge.
- Response: INTERRUPT re-pulses every 8+2 cycles with the same SRC_ID.
REQ-036 Collision and reset:
- Stimulus: acknowledge coincident with a new rise of the same source.
- Response: PENDING bit stays 1 and the source is re-serviced.
- Stimulus: RESET in WAIT_ACK.
- Response: all outputs return to their reset values on the next edge.
REQ-037 Reset hold-off:
- Stimulus: SRC_REQ=4'b1111 held through reset release.
- Response: no interrupt is generated.
